// File: rtl/sl_preceptron_seq_if.sv
// Bundles the signals of the perceptron sequencer, except clock and reset.
//   Sample stream  : start_vector, done_vector, sample_valid, sample, bias
//   Weight memory  : w_rd_en, w_addr (out), w_data (in, one cycle after w_rd_en)
//   Result channel : result_valid, result_acc, result_class (out), result_ready (in)
//   Status         : busy, len_err, overrun
// Modports:
//   master - the sequencer. It drives weight reads, results and status.
//   slave  - the environment. It drives the sample stream, weights and result_ready.
interface sl_preceptron_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                         start_vector;
    logic                         done_vector;
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] bias;
    logic                         w_rd_en;
    logic        [ADDR_WIDTH-1:0] w_addr;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic                         result_valid;
    logic                         result_ready;
    logic signed [ACC_WIDTH-1:0]  result_acc;
    logic                         result_class;
    logic                         busy;
    logic                         len_err;
    logic                         overrun;

    modport master (
        input  start_vector, done_vector, sample_valid, sample, bias, w_data, result_ready,
        output w_rd_en, w_addr, result_valid, result_acc, result_class, busy, len_err, overrun
    );

    modport slave (
        output start_vector, done_vector, sample_valid, sample, bias, w_data, result_ready,
        input  w_rd_en, w_addr, result_valid, result_acc, result_class, busy, len_err, overrun
    );
endinterface

// File: rtl/sl_preceptron_seq.sv
// Perceptron vector sequencer.
// It consumes a serialized sample stream framed by start_vector and done_vector. For every
// accepted sample it reads the matching weight, which arrives one cycle later, and accumulates
// sample*weight. When VEC_LEN samples have been accepted it adds the bias and applies the
// activation. It then offers one result per vector over a valid/ready handshake.
// Ports:
//   clk    - clock
//   rst_n  - synchronous, active-low reset
//   bus    - sl_preceptron_seq_if.master (sample stream, weight memory, result, status)
// Build option:
//   SL_PRECEPTRON_SEQ_RELU_EN - when defined, result_acc is clamped at zero (ReLU).
//   result_class is always the step function of (acc + bias).
module sl_preceptron_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LEN    = 52,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    sl_preceptron_seq_if.master bus
);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    // One extra bit, so the counter can hold VEC_LEN itself.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(VEC_LEN - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {StIdle, StAccum, StDrain, StBias, StOut} state_e;

    state_e                       state_q;
    logic        [ADDR_WIDTH:0]   elem_cnt_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic                         prod_pend_q;
    logic                         result_valid_q;
    logic signed [ACC_WIDTH-1:0]  result_acc_q;
    logic                         result_class_q;
    logic                         len_err_q;
    logic                         overrun_q;

    logic                         accept;
    logic                         last_accept;
    logic                         short_done;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  biased;
    logic                         biased_pos;

    assign accept      = (state_q == StAccum) && bus.sample_valid;
    assign last_accept = accept && (elem_cnt_q == CNT_LAST);
    // A done_vector that arrives together with the final sample completes the vector normally.
    assign short_done  = (state_q == StAccum) && bus.done_vector && !last_accept;

    // The operands are sign-extended first, so the full signed product fits without loss.
    assign product = PROD_WIDTH'(sample_q) * PROD_WIDTH'(bus.w_data);
    // w_data answers the read issued one cycle earlier, which is marked by prod_pend_q.
    assign acc_sum = prod_pend_q ? acc_q + ACC_WIDTH'(product) : acc_q;

    assign biased     = acc_q + ACC_WIDTH'(bus.bias);
    assign biased_pos = !biased[ACC_WIDTH-1] && (biased != '0);

    assign bus.w_rd_en      = accept;
    assign bus.w_addr       = accept ? elem_cnt_q[ADDR_WIDTH-1:0] : '0;
    assign bus.busy         = (state_q != StIdle);
    assign bus.result_valid = result_valid_q;
    assign bus.result_acc   = result_acc_q;
    assign bus.result_class = result_class_q;
    assign bus.len_err      = len_err_q;
    assign bus.overrun      = overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            elem_cnt_q     <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            prod_pend_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_acc_q   <= '0;
            result_class_q <= 1'b0;
            len_err_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            len_err_q   <= 1'b0;
            overrun_q   <= bus.start_vector && (state_q != StIdle);
            prod_pend_q <= accept;
            acc_q       <= acc_sum;
            if (accept) begin
                sample_q <= bus.sample;
            end

            case (state_q)
                StIdle: begin
                    if (bus.start_vector) begin
                        state_q    <= StAccum;
                        elem_cnt_q <= '0;
                        acc_q      <= '0;
                    end
                end
                StAccum: begin
                    if (short_done) begin
                        // Abort the vector. Any product still in flight is dropped as well.
                        state_q     <= StIdle;
                        len_err_q   <= 1'b1;
                        acc_q       <= '0;
                        elem_cnt_q  <= '0;
                        prod_pend_q <= 1'b0;
                    end else if (accept) begin
                        elem_cnt_q <= elem_cnt_q + CNT_ONE;
                        if (last_accept) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The last product is added here through the default acc_q update.
                    state_q <= StBias;
                end
                StBias: begin
`ifdef SL_PRECEPTRON_SEQ_RELU_EN
                    result_acc_q <= biased[ACC_WIDTH-1] ? '0 : biased;
`else
                    result_acc_q <= biased;
`endif
                    result_class_q <= biased_pos;
                    result_valid_q <= 1'b1;
                    state_q        <= StOut;
                end
                StOut: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sl_preceptron_seq.sv
// Self-checking bench for sl_preceptron_seq, built with VEC_LEN=4 and ACC_WIDTH=16.
// Inputs are driven on the falling clock edge and outputs are sampled there.
// A plain-arithmetic model gives the expected result for every vector.
module tb_sl_preceptron_seq;
    localparam int DW  = 8;
    localparam int VL  = 4;
    localparam int AW  = 16;
    localparam int ADW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sl_preceptron_seq_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

    sl_preceptron_seq #(
        .DATA_WIDTH(DW),
        .VEC_LEN   (VL),
        .ACC_WIDTH (AW),
        .ADDR_WIDTH(ADW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic signed [DW-1:0] mem [VL];
    logic signed [DW-1:0] smp [VL];
    logic signed [AW-1:0] got_acc;
    logic                 got_cls;

    // Weight memory with a read latency of one cycle. It returns junk when no read is issued.
    always @(posedge clk) begin
        bus.w_data <= bus.w_rd_en ? mem[bus.w_addr] : DW'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.result_valid, 0);
        check({tag, "_acc"}, bus.result_acc, 0);
        check({tag, "_class"}, bus.result_class, 0);
        check({tag, "_rd_en"}, bus.w_rd_en, 0);
        check({tag, "_addr"}, bus.w_addr, 0);
        check({tag, "_len_err"}, bus.len_err, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Start a vector, then feed smp[] with gaps of min_gap..max_gap cycles between samples.
    task automatic feed(input int min_gap, input int max_gap, input bit done_last);
        bus.start_vector = 1'b1;
        bus.sample_valid = 1'($urandom_range(1, 0));
        bus.sample       = DW'($urandom);
        #1 check("rd_en_in_start", bus.w_rd_en, 0);
        tick();
        bus.start_vector = 1'b0;
        check("busy_accum", bus.busy, 1);
        for (int i = 0; i < VL; i++) begin
            repeat ($urandom_range(max_gap, min_gap)) begin
                bus.sample_valid = 1'b0;
                tick();
            end
            bus.sample_valid = 1'b1;
            bus.sample       = smp[i];
            bus.done_vector  = done_last && (i == VL - 1);
            #1;
            check("rd_en", bus.w_rd_en, 1);
            check("addr", bus.w_addr, i);
            tick();
        end
        bus.done_vector  = 1'b0;
        bus.sample_valid = 1'b0;
    endtask

    task automatic run_vec(input int min_gap, input int max_gap, input int hold,
                           input bit ovr, input bit done_last, input bit ready_early);
        int                   sum;
        logic signed [AW-1:0] exp_acc;
        logic                 exp_cls;
        sum = bus.bias;
        for (int i = 0; i < VL; i++) sum += smp[i] * mem[i];
        exp_acc = sum[AW-1:0];
        exp_cls = (exp_acc > 0);
`ifdef SL_PRECEPTRON_SEQ_RELU_EN
        if (exp_acc < 0) exp_acc = '0;
`endif
        feed(min_gap, max_gap, done_last);
        bus.result_ready = ready_early;
        // The result appears three cycles after the last sample. Samples after it are ignored.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) check("no_len_err", bus.len_err, 0);
            check("latency_valid", bus.result_valid, (k == 2) ? 1 : 0);
            if (k < 2) begin
                bus.sample_valid = 1'($urandom_range(1, 0));
                bus.sample       = DW'($urandom);
                #1 check("rd_en_post", bus.w_rd_en, 0);
                tick();
            end
        end
        bus.sample_valid = 1'b0;
        got_acc = bus.result_acc;
        got_cls = bus.result_class;
        check("result_acc", bus.result_acc, exp_acc);
        check("result_class", bus.result_class, exp_cls);
        if (!ready_early) begin
            for (int h = 0; h < hold; h++) begin
                bus.start_vector = ovr && (h == 1);
                bus.done_vector  = (h == 2);
                tick();
                check("hold_valid", bus.result_valid, 1);
                check("hold_acc", bus.result_acc, exp_acc);
                check("hold_class", bus.result_class, exp_cls);
                check("hold_overrun", bus.overrun, (ovr && h == 1) ? 1 : 0);
                check("hold_len_err", bus.len_err, 0);
            end
            bus.start_vector = 1'b0;
            bus.done_vector  = 1'b0;
            bus.result_ready = 1'b1;
        end
        tick();
        check("done_valid", bus.result_valid, 0);
        check("done_busy", bus.busy, 0);
        bus.result_ready = 1'b0;
    endtask

    initial begin
        logic signed [AW-1:0] exp_neg;
        bus.start_vector = 1'b0;
        bus.done_vector  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.bias         = '0;
        bus.result_ready = 1'b0;
        rst_n            = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // sample_valid alone does nothing in IDLE.
        bus.sample_valid = 1'b1;
        #1 check("idle_rd_en", bus.w_rd_en, 0);
        tick();
        check("idle_busy", bus.busy, 0);
        bus.sample_valid = 1'b0;

        // 1..4 times 1..4, no bias, back-to-back samples.
        for (int i = 0; i < VL; i++) begin
            mem[i] = DW'(i + 1);
            smp[i] = DW'(i + 1);
        end
        run_vec(0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("t1_acc_const", got_acc, 30);
        check("t1_class_const", got_cls, 1);

        // Same vector, bias -40, one idle cycle between samples, and a held result with overrun.
        bus.bias = -8'sd40;
        run_vec(1, 1, 5, 1'b1, 1'b0, 1'b0);
`ifdef SL_PRECEPTRON_SEQ_RELU_EN
        exp_neg = '0;
`else
        exp_neg = -16'sd10;
`endif
        check("t2_acc_const", got_acc, exp_neg);
        check("t2_class_const", got_cls, 0);

        // done_vector after two samples aborts the vector.
        bus.bias = '0;
        bus.start_vector = 1'b1;
        tick();
        bus.start_vector = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample = smp[i];
            tick();
        end
        bus.sample_valid = 1'b0;
        bus.done_vector  = 1'b1;
        tick();
        bus.done_vector = 1'b0;
        check("abort_len_err", bus.len_err, 1);
        check("abort_busy", bus.busy, 0);
        tick();
        check("abort_len_err_pulse", bus.len_err, 0);
        repeat (3) begin
            tick();
            check("abort_no_valid", bus.result_valid, 0);
        end
        run_vec(0, 1, 2, 1'b0, 1'b0, 1'b0);

        // done_vector with the third sample still counts as short.
        bus.start_vector = 1'b1;
        tick();
        bus.start_vector = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample       = smp[i];
            bus.done_vector  = (i == 2);
            tick();
        end
        bus.sample_valid = 1'b0;
        bus.done_vector  = 1'b0;
        check("abort3_len_err", bus.len_err, 1);
        check("abort3_busy", bus.busy, 0);

        // done_vector with the final sample completes the vector normally.
        run_vec(0, 0, 1, 1'b0, 1'b1, 1'b0);

        // -128 * -128 four times wraps to zero in 16 bits.
        for (int i = 0; i < VL; i++) begin
            mem[i] = -8'sd128;
            smp[i] = -8'sd128;
        end
        run_vec(0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("wrap_acc_const", got_acc, 0);
        check("wrap_class_const", got_cls, 0);

        // Reset while in DRAIN discards the vector.
        for (int i = 0; i < VL; i++) begin
            mem[i] = DW'($urandom);
            smp[i] = DW'($urandom);
        end
        feed(0, 0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero("drain_reset");
        rst_n = 1'b1;
        tick();
        check("drain_reset_valid_after", bus.result_valid, 0);
        run_vec(0, 1, 1, 1'b0, 1'b0, 1'b0);

        // Random vectors.
        for (int n = 0; n < 16; n++) begin
            int hold;
            for (int i = 0; i < VL; i++) begin
                mem[i] = DW'($urandom);
                smp[i] = DW'($urandom);
            end
            bus.bias = DW'($urandom);
            hold = $urandom_range(4, 0);
            run_vec(0, 2, hold, (hold >= 3), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
